down_timer: RTL
===============

DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 32, sets the counter and period width in bits (legal range 2..64).
REQ-002 CLK  input  1  Single clock; all state updates on the rising edge.
REQ-003 RSTN  input  1  Asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 EN  input  1  Tick enable; the counter decrements only in cycles where EN=1.
REQ-005 START  input  1  Single-cycle request to (re)load the period and run.
REQ-006 STOP  input  1  Single-cycle request to abort and return to IDLE.
REQ-007 MODE  input  1  Sampled at START: 0 = one-shot, 1 = periodic.
REQ-008 LOAD_VALUE  input  WIDTH  Period in enabled ticks, sampled at START.
REQ-009 ACK  input  1  Acknowledge; clears PENDING and OVERRUN.
REQ-010 VALUE  output  WIDTH  Current remaining count.
REQ-011 BUSY  output  1  High while in state RUN.
REQ-012 EXPIRED  output  1  Registered one-cycle pulse per expiry event.
REQ-013 PENDING  output  1  Sticky expiry flag, held until ACK.
REQ-014 OVERRUN  output  1  Sticky flag: an expiry occurred while PENDING was already set.

Function
REQ-015 The block SHALL have two states, IDLE and RUN; BUSY SHALL equal (state==RUN).
REQ-016 START with LOAD_VALUE!=0 and STOP=0 SHALL, in either state, latch LOAD_VALUE into a period register, latch MODE, set VALUE=LOAD_VALUE and enter RUN on the next edge.
REQ-017 START with LOAD_VALUE==0 SHALL be ignored, leaving state and VALUE unchanged.
REQ-018 STOP SHALL move to IDLE with VALUE=0 on the next edge; STOP SHALL win over a simultaneous START or expiry.
REQ-019 In RUN with EN=1 and VALUE>1, VALUE SHALL decrement by 1; with EN=0, VALUE SHALL hold.
REQ-020 In RUN with EN=1 and VALUE==1, an expiry event SHALL occur: EXPIRED=1 in the following cycle only; periodic mode reloads VALUE from the period register and stays in RUN; one-shot mode sets VALUE=0 and enters IDLE.
REQ-021 A period of N SHALL produce an expiry on exactly the Nth enabled cycle after the START edge; periodic mode SHALL repeat every N enabled cycles with no gap.
REQ-022 LOAD_VALUE and MODE changes during RUN SHALL have no effect until the next START.
REQ-023 START coincident with an expiry cycle SHALL reload from the new LOAD_VALUE and SHALL suppress that expiry.
REQ-024 An expiry SHALL set PENDING; if PENDING was already 1 and ACK=0 in that cycle, it SHALL also set OVERRUN.
REQ-025 ACK SHALL clear PENDING and OVERRUN; ACK coincident with an expiry SHALL leave PENDING=1 and OVERRUN unchanged.
REQ-026 In IDLE, EN, ACK-free cycles SHALL leave all outputs unchanged.

Reset
REQ-027 RSTN=0 SHALL immediately force state IDLE, VALUE=0, the period register to 0, MODE to one-shot, and BUSY, EXPIRED, PENDING and OVERRUN to 0, including during RUN.
REQ-028 After RSTN deasserts, the block SHALL stay in IDLE until a valid START.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, RUN) and the MODE constants (ONE_SHOT=0, PERIODIC=1).
REQ-030 The block SHALL be a single module with no sub-module; the decrement, reload and flag logic are local.

Verification
REQ-031 WIDTH=8, START with LOAD_VALUE=5, MODE=0, EN=1 constant -> VALUE 5,4,3,2,1, EXPIRED pulses once in the cycle after VALUE=1, VALUE=0, BUSY=0, PENDING=1.
REQ-032 LOAD_VALUE=3, MODE=1, EN toggling 1,0,1,1 -> VALUE holds on EN=0, and EXPIRED pulses on every 3rd enabled cycle, for 4 periods.
REQ-033 Periodic with period 2 and no ACK -> second expiry sets OVERRUN=1; ACK -> PENDING=0 and OVERRUN=0; ACK in an expiry cycle -> PENDING stays 1.
REQ-034 START and STOP in the same cycle during RUN -> IDLE with VALUE=0; START with LOAD_VALUE=0 in IDLE -> no change.
REQ-035 START with LOAD_VALUE=9 in the cycle where VALUE=1 -> no EXPIRED pulse and VALUE=9.
REQ-036 RSTN asserted asynchronously mid-RUN with VALUE=0x40 -> all outputs 0 before the next clock edge, and the block stays in IDLE after release.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block.
package down_timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic ONE_SHOT = 1'b0;
   localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/down_timer.sv
// Down-counting tick timer with one-shot / periodic modes and
// sticky expiry flags (PENDING, OVERRUN).
module down_timer
   import down_timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             EN,
   input  logic             START,
   input  logic             STOP,
   input  logic             MODE,
   input  logic [WIDTH-1:0] LOAD_VALUE,
   input  logic             ACK,
   output logic [WIDTH-1:0] VALUE,
   output logic             BUSY,
   output logic             EXPIRED,
   output logic             PENDING,
   output logic             OVERRUN
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   logic             expired_q, expired_d;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;
   logic             start_ok;
   logic             expiry;

   assign start_ok = START && (LOAD_VALUE != '0);

   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      period_d  = period_q;
      mode_d    = mode_q;
      expiry    = 1'b0;
      pending_d = pending_q;
      overrun_d = overrun_q;

      // STOP beats START, and START beats any expiry due this cycle
      if (STOP) begin
         state_d = IDLE;
         value_d = '0;
      end else if (start_ok) begin
         state_d  = RUN;
         value_d  = LOAD_VALUE;
         period_d = LOAD_VALUE;
         mode_d   = MODE;
      end else if (state_q == RUN && EN) begin
         if (value_q > ONE) begin
            value_d = value_q - ONE;
         end else begin
            expiry = 1'b1;
            if (mode_q == PERIODIC) begin
               value_d = period_q;
            end else begin
               value_d = '0;
               state_d = IDLE;
            end
         end
      end

      if (expiry) begin
         pending_d = 1'b1;
         if (pending_q && !ACK) begin
            overrun_d = 1'b1;
         end
      end else if (ACK) begin
         pending_d = 1'b0;
         overrun_d = 1'b0;
      end

      expired_d = expiry;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= IDLE;
         value_q   <= '0;
         period_q  <= '0;
         mode_q    <= ONE_SHOT;
         expired_q <= 1'b0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         period_q  <= period_d;
         mode_q    <= mode_d;
         expired_q <= expired_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign VALUE   = value_q;
   assign BUSY    = (state_q == RUN);
   assign EXPIRED = expired_q;
   assign PENDING = pending_q;
   assign OVERRUN = overrun_q;

endmodule
